// File: rtl/fp_div_iter.sv
// Iterative IEEE-754 binary32 divider: restoring radix-2 mantissa division,
// fixed 29-cycle latency from accept to done, all five rounding modes and flags.
module fp_div_iter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [31:0] lhs,
  input  logic [31:0] rhs,
  input  logic [2:0]  rm,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  fflags
);
  localparam int unsigned QW = 26;
  localparam int unsigned RW = 27;
  localparam int unsigned EW = 10;
  localparam logic [4:0] ITER_LAST = 5'd25;

  typedef enum logic [1:0] {IDLE, PREP, ITER, ROUND} state_t;

  state_t               r_state, w_state_nx;
  logic [31:0]          r_a, r_b;
  logic [2:0]           r_rm;
  logic [4:0]           r_cnt;
  logic                 r_sign;
  logic signed [EW-1:0] r_exp;
  logic [23:0]          r_mb;
  logic [RW-1:0]        r_rem;
  logic [QW-1:0]        r_q;
  logic                 r_spec;
  logic [31:0]          r_spec_res;
  logic [4:0]           r_spec_flg;
  logic                 r_busy, r_done;
  logic [31:0]          r_result;
  logic [4:0]           r_fflags;

  function automatic logic [4:0] lzc23(input logic [22:0] f);
    logic [4:0] n;
    n = 5'd23;
    for (int i = 0; i < 23; i++) if (f[i]) n = 5'(22 - i);
    return n;
  endfunction

  // Returns {biased exponent (signed), 1.f mantissa}; subnormals pushed below exponent 1.
  function automatic logic [EW+23:0] unpack_norm(input logic [30:0] x);
    logic [4:0]    lz;
    logic [23:0]   m;
    logic [EW-1:0] e;
    lz = lzc23(x[22:0]);
    if (x[30:23] != 8'd0) begin
      m = {1'b1, x[22:0]};
      e = EW'(x[30:23]);
    end else begin
      m = {1'b0, x[22:0]} << (lz + 5'd1);
      e = -{5'd0, lz};
    end
    return {e, m};
  endfunction

  function automatic logic rnd_inc(input logic [2:0] mode, input logic s, input logic lsb,
                                   input logic g, input logic st);
    case (mode)
      3'b001:  return 1'b0;
      3'b010:  return s & (g | st);
      3'b011:  return ~s & (g | st);
      3'b100:  return g;
      default: return g & (st | lsb);
    endcase
  endfunction

  // Operand unpack and classification
  logic signed [EW-1:0] w_ea, w_eb;
  logic [23:0]          w_ma, w_mb;
  logic w_a_zero, w_a_inf, w_a_nan, w_a_snan, w_b_zero, w_b_inf, w_b_nan, w_b_snan, w_sign;
  assign {w_ea, w_ma} = unpack_norm(r_a[30:0]);
  assign {w_eb, w_mb} = unpack_norm(r_b[30:0]);
  assign w_a_zero = (r_a[30:0] == 31'd0);
  assign w_b_zero = (r_b[30:0] == 31'd0);
  assign w_a_inf  = (r_a[30:23] == 8'hFF) && (r_a[22:0] == 23'd0);
  assign w_b_inf  = (r_b[30:23] == 8'hFF) && (r_b[22:0] == 23'd0);
  assign w_a_nan  = (r_a[30:23] == 8'hFF) && (r_a[22:0] != 23'd0);
  assign w_b_nan  = (r_b[30:23] == 8'hFF) && (r_b[22:0] != 23'd0);
  assign w_a_snan = w_a_nan & ~r_a[22];
  assign w_b_snan = w_b_nan & ~r_b[22];
  assign w_sign   = r_a[31] ^ r_b[31];

  logic        w_spec;
  logic [31:0] w_spec_res;
  logic [4:0]  w_spec_flg;
  always_comb begin
    w_spec     = 1'b1;
    w_spec_res = 32'd0;
    w_spec_flg = 5'd0;
    if (w_a_nan | w_b_nan | (w_a_zero & w_b_zero) | (w_a_inf & w_b_inf)) begin
      w_spec_res = 32'h7FC0_0000;
      w_spec_flg = {w_a_snan | w_b_snan | (w_a_zero & w_b_zero) | (w_a_inf & w_b_inf), 4'd0};
    end else if (w_a_inf) begin
      w_spec_res = {w_sign, 8'hFF, 23'd0};
    end else if (w_b_zero) begin
      w_spec_res = {w_sign, 8'hFF, 23'd0};
      w_spec_flg = 5'b01000;
    end else if (w_b_inf | w_a_zero) begin
      w_spec_res = {w_sign, 31'd0};
    end else begin
      w_spec = 1'b0;
    end
  end

  // One restoring step per ITER cycle
  logic [RW-1:0] w_diff;
  logic          w_ge;
  assign w_diff = r_rem - {3'd0, r_mb};
  assign w_ge   = ~w_diff[RW-1];

  // Normalize, denormalize, round
  logic [QW-1:0]        w_qn;
  logic [QW-2:0]        w_qs;
  logic signed [EW-1:0] w_en, w_sh;
  logic [7:0]           w_ex;
  logic [30:0]          w_pack, w_omag;
  logic [31:0]          w_res;
  logic [4:0]           w_flg;
  logic w_st0, w_lost, w_stk, w_inc, w_nx, w_cy, w_tiny, w_ovf;
  always_comb begin
    w_qn   = r_q[QW-1] ? r_q : {r_q[QW-2:0], 1'b0};
    w_en   = r_q[QW-1] ? r_exp : r_exp - 10'sd1;
    w_st0  = |r_rem;
    w_sh   = 10'sd1 - w_en;
    w_qs   = w_qn[QW-2:0];
    w_lost = 1'b0;
    w_ex   = w_en[7:0];
    if (w_en < 10'sd1) begin
      w_ex = 8'd0;
      if (w_sh > 10'sd26) begin
        w_qs   = '0;
        w_lost = |w_qn;
      end else begin
        w_qs   = (QW-1)'(w_qn >> w_sh[4:0]);
        w_lost = |(w_qn & ~({QW{1'b1}} << w_sh[4:0]));
      end
    end
    w_stk  = w_qs[0] | w_st0 | w_lost;
    w_inc  = rnd_inc(r_rm, r_sign, w_qs[2], w_qs[1], w_stk);
    // carry out of the fraction lands in the exponent field, which renormalizes for free
    w_pack = {w_ex, w_qs[24:2]} + 31'(w_inc);
    w_nx   = w_qs[1] | w_stk;
    w_cy   = (&w_qn[25:2]) & rnd_inc(r_rm, r_sign, w_qn[2], w_qn[1], w_qn[0] | w_st0);
    w_tiny = (w_en < 10'sd0) | ((w_en == 10'sd0) & ~w_cy);
    w_ovf  = (w_en > 10'sd254) | (w_pack[30:23] == 8'hFF);
    case (r_rm)
      3'b001:  w_omag = 31'h7F7F_FFFF;
      3'b010:  w_omag = r_sign ? 31'h7F80_0000 : 31'h7F7F_FFFF;
      3'b011:  w_omag = r_sign ? 31'h7F7F_FFFF : 31'h7F80_0000;
      default: w_omag = 31'h7F80_0000;
    endcase
    w_res = w_ovf ? {r_sign, w_omag} : {r_sign, w_pack};
    w_flg = w_ovf ? 5'b00101 : {3'b000, w_tiny & w_nx, w_nx};
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (req) w_state_nx = PREP;
      PREP:    w_state_nx = ITER;
      ITER:    if (r_cnt == 5'd0) w_state_nx = ROUND;
      ROUND:   w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
    if (flush) w_state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= '0; r_b <= '0; r_rm <= '0; r_cnt <= '0;
      r_sign <= 1'b0; r_exp <= '0; r_mb <= '0; r_rem <= '0; r_q <= '0;
      r_spec <= 1'b0; r_spec_res <= '0; r_spec_flg <= '0;
      r_busy <= 1'b0; r_done <= 1'b0; r_result <= '0; r_fflags <= '0;
    end else begin
      r_done <= 1'b0;
      r_busy <= (w_state_nx != IDLE);
      case (r_state)
        IDLE: if (req && !flush) begin
          r_a  <= lhs;
          r_b  <= rhs;
          r_rm <= rm;
        end
        PREP: begin
          r_sign     <= w_sign;
          r_exp      <= w_ea - w_eb + 10'sd127;
          r_mb       <= w_mb;
          r_rem      <= {3'd0, w_ma};
          r_q        <= '0;
          r_cnt      <= ITER_LAST;
          r_spec     <= w_spec;
          r_spec_res <= w_spec_res;
          r_spec_flg <= w_spec_flg;
        end
        ITER: begin
          r_q   <= {r_q[QW-2:0], w_ge};
          r_rem <= (w_ge ? w_diff : r_rem) << 1;
          if (r_cnt != 5'd0) r_cnt <= r_cnt - 5'd1;
        end
        ROUND: if (!flush) begin
          r_done   <= 1'b1;
          r_result <= r_spec ? r_spec_res : w_res;
          r_fflags <= r_spec ? r_spec_flg : w_flg;
        end
        default: ;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign fflags = r_fflags;
endmodule

// File: tb/tb_fp_div_iter.sv
// Self-checking bench for fp_div_iter: directed corners, control corners and
// random operands against an exact-integer division reference model.
module tb_fp_div_iter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] lhs = '0, rhs = '0;
  logic [2:0]  rm = '0;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  fflags;

  int vectors = 0;
  int errors  = 0;
  logic [31:0] last_res = '0;
  logic [4:0]  last_flg = '0;

  fp_div_iter dut (.clk(clk), .rst_n(rst_n), .req(req), .lhs(lhs), .rhs(rhs), .rm(rm),
                   .flush(flush), .busy(busy), .done(done), .result(result), .fflags(fflags));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  m;
    logic [31:0] r;
    logic [4:0]  f;
  } vec_t;

  localparam int NDIR = 23;
  localparam vec_t DIR [NDIR] = '{
    '{32'h3F800000, 32'h40400000, 3'd0, 32'h3EAAAAAB, 5'h01},
    '{32'h3F800000, 32'h40400000, 3'd1, 32'h3EAAAAAA, 5'h01},
    '{32'h3F800000, 32'h40400000, 3'd5, 32'h3EAAAAAB, 5'h01},
    '{32'h3F800000, 32'h40400000, 3'd2, 32'h3EAAAAAA, 5'h01},
    '{32'h3F800000, 32'h40400000, 3'd3, 32'h3EAAAAAB, 5'h01},
    '{32'h3F800000, 32'h00000000, 3'd0, 32'h7F800000, 5'h08},
    '{32'h00000000, 32'h00000000, 3'd0, 32'h7FC00000, 5'h10},
    '{32'h7F800001, 32'h3F800000, 3'd0, 32'h7FC00000, 5'h10},
    '{32'h7FC00000, 32'h3F800000, 3'd0, 32'h7FC00000, 5'h00},
    '{32'h7F800000, 32'h7F800000, 3'd0, 32'h7FC00000, 5'h10},
    '{32'h7F800000, 32'h00000000, 3'd0, 32'h7F800000, 5'h00},
    '{32'hFF800000, 32'h3F800000, 3'd0, 32'hFF800000, 5'h00},
    '{32'h3F800000, 32'hFF800000, 3'd0, 32'h80000000, 5'h00},
    '{32'h80000000, 32'h40000000, 3'd0, 32'h80000000, 5'h00},
    '{32'h7F7FFFFF, 32'h3F000000, 3'd0, 32'h7F800000, 5'h05},
    '{32'h7F7FFFFF, 32'h3F000000, 3'd1, 32'h7F7FFFFF, 5'h05},
    '{32'hFF7FFFFF, 32'h3F000000, 3'd2, 32'hFF800000, 5'h05},
    '{32'hFF7FFFFF, 32'h3F000000, 3'd3, 32'hFF7FFFFF, 5'h05},
    '{32'h00000001, 32'h40000000, 3'd0, 32'h00000000, 5'h03},
    '{32'h00800000, 32'h40000000, 3'd0, 32'h00400000, 5'h00},
    '{32'h00000001, 32'h40000000, 3'd3, 32'h00000001, 5'h03},
    '{32'hBF800000, 32'hC0400000, 3'd2, 32'h3EAAAAAA, 5'h01},
    '{32'h00400000, 32'h3F000000, 3'd0, 32'h00800000, 5'h00}
  };

  function automatic bit round_up(input logic [2:0] m, input bit s, input bit lsb,
                                  input bit g, input bit st);
    case (m)
      3'd0:    return g && (st || lsb);
      3'd1:    return 1'b0;
      3'd2:    return s && (g || st);
      3'd3:    return !s && (g || st);
      default: return g;
    endcase
  endfunction

  // Exact reference: integer quotient of normalized significands, rounded at the target ulp.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic [2:0] m0,
                                  output logic [31:0] r, output logic [4:0] f);
    logic [2:0] m;
    bit s, an, bn, asn, bsn, ai, bi, az, bz, g, st, nx, tiny, g2, st2;
    longint unsigned ma, mb, q, rr, kept, kept2;
    int xa, xb, base, p, e, e2, lsbx, k, k2, fld;
    m   = (m0 > 3'd4) ? 3'd0 : m0;
    s   = a[31] ^ b[31];
    an  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    bn  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    asn = an && !a[22];
    bsn = bn && !b[22];
    ai  = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    bi  = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    az  = (a[30:0] == 0);
    bz  = (b[30:0] == 0);
    r = '0;
    f = '0;
    if (an || bn || (az && bz) || (ai && bi)) begin
      r = 32'h7FC00000;
      f = (asn || bsn || (az && bz) || (ai && bi)) ? 5'h10 : 5'h00;
      return;
    end
    if (ai) begin r = {s, 8'hFF, 23'd0}; return; end
    if (bz) begin r = {s, 8'hFF, 23'd0}; f = 5'h08; return; end
    if (bi || az) begin r = {s, 31'd0}; return; end
    ma = 64'(a[22:0]);
    mb = 64'(b[22:0]);
    xa = (a[30:23] != 0) ? int'(a[30:23]) - 150 : -149;
    xb = (b[30:23] != 0) ? int'(b[30:23]) - 150 : -149;
    if (a[30:23] != 0) ma += 64'h800000;
    if (b[30:23] != 0) mb += 64'h800000;
    while (ma < 64'h800000) begin ma = ma << 1; xa--; end
    while (mb < 64'h800000) begin mb = mb << 1; xb--; end
    q    = (ma << 38) / mb;
    rr   = (ma << 38) % mb;
    base = xa - xb - 38;
    p = 0;
    for (int i = 0; i < 64; i++) if (q[i]) p = i;
    e    = p + base;
    lsbx = (e - 23 > -149) ? e - 23 : -149;
    k    = lsbx - base;
    if (k > 60) begin
      kept = 0; g = 0; st = 1;
    end else begin
      kept = q >> k;
      g    = q[k-1];
      st   = (q & ((64'd1 << (k - 1)) - 1)) != 0;
    end
    st = st || (rr != 0);
    nx = g || st;
    kept = kept + 64'(round_up(m, s, kept[0], g, st));
    if (kept == 64'h1000000) begin kept = 64'h800000; lsbx++; end
    k2    = p - 23;
    kept2 = q >> k2;
    g2    = q[k2-1];
    st2   = ((q & ((64'd1 << (k2 - 1)) - 1)) != 0) || (rr != 0);
    kept2 = kept2 + 64'(round_up(m, s, kept2[0], g2, st2));
    e2    = (kept2 == 64'h1000000) ? e + 1 : e;
    tiny  = (e2 < -126);
    fld   = lsbx + 150;
    if (kept >= 64'h800000 && fld >= 255) begin
      case (m)
        3'd1:    r = {s, 31'h7F7FFFFF};
        3'd2:    r = s ? 32'hFF800000 : 32'h7F7FFFFF;
        3'd3:    r = s ? 32'hFF7FFFFF : 32'h7F800000;
        default: r = {s, 31'h7F800000};
      endcase
      f = 5'h05;
    end else begin
      r = (kept < 64'h800000) ? {s, 8'd0, kept[22:0]} : {s, 8'(fld), kept[22:0]};
      f = {3'b000, tiny && nx, nx};
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of cycle T+1 with inputs scrambled.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] m);
    lhs = a; rhs = b; rm = m; req = 1'b1;
    @(negedge clk);
    req = 1'b0; lhs = $urandom; rhs = $urandom; rm = 3'($urandom);
  endtask

  // Checks busy for cycles from..T+28, then done and results in cycle T+29.
  task automatic finish_op(input string tag, input logic [31:0] er, input logic [4:0] ef, input int from);
    logic ok;
    ok = 1'b1;
    for (int c = from; c <= 28; c++) begin
      if (busy !== 1'b1 || done !== 1'b0) ok = 1'b0;
      @(negedge clk);
    end
    chk({tag, "_busy"}, 32'(ok), 32'd1);
    chk({tag, "_done"}, {30'd0, done, busy}, 32'd2);
    chk({tag, "_res"}, result, er);
    chk({tag, "_flg"}, 32'(fflags), 32'(ef));
    last_res = er;
    last_flg = ef;
  endtask

  task automatic quiet(input string tag, input int n);
    logic ok;
    ok = 1'b1;
    for (int c = 0; c < n; c++) begin
      if (done !== 1'b0 || busy !== 1'b0) ok = 1'b0;
      @(negedge clk);
    end
    chk({tag, "_quiet"}, 32'(ok), 32'd1);
    chk({tag, "_hold_res"}, result, last_res);
    chk({tag, "_hold_flg"}, 32'(fflags), 32'(last_flg));
  endtask

  initial begin
    logic [31:0] a, b, er;
    logic [2:0]  m;
    logic [4:0]  ef;

    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_res", result, 32'd0);
    chk("rst_flg", 32'(fflags), 32'd0);

    // Release reset and request on the same cycle: accepted at the first edge
    @(negedge clk);
    rst_n = 1'b1;
    issue(32'h40400000, 32'h40000000, 3'd0);
    finish_op("div3_2", 32'h3FC00000, 5'h00, 1);
    @(negedge clk);
    chk("pulse_done", 32'(done), 32'd0);
    chk("hold_res", result, 32'h3FC00000);

    // Directed vectors, each issued in the previous done cycle
    for (int i = 0; i < NDIR; i++) begin
      issue(DIR[i].a, DIR[i].b, DIR[i].m);
      finish_op($sformatf("dir%0d", i), DIR[i].r, DIR[i].f, 1);
    end
    @(negedge clk);

    // req while busy is ignored and not queued
    issue(32'h40400000, 32'h40000000, 3'd0);
    repeat (4) @(negedge clk);
    lhs = 32'h3F800000; rhs = 32'h40400000; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    finish_op("busy_req", 32'h3FC00000, 5'h00, 6);
    @(negedge clk);
    chk("busy_req_noqueue", {30'd0, done, busy}, 32'd0);

    // Flush at T+10
    issue(32'h3F800000, 32'h40400000, 3'd0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    quiet("flush", 30);

    // Flush together with req in idle
    lhs = 32'h3F800000; rhs = 32'h40400000; req = 1'b1; flush = 1'b1;
    @(negedge clk);
    req = 1'b0; flush = 1'b0;
    quiet("flush_req", 30);

    // Reset pulse at T+15: outputs clear without a clock edge
    issue(32'h3F800000, 32'h40400000, 3'd0);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_res", result, 32'd0);
    chk("midrst_flg", 32'(fflags), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_res = '0;
    last_flg = '0;
    quiet("midrst", 35);

    // Random operands, back to back
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      m = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        1: begin a[30:23] = 8'($urandom_range(200, 254)); b[30:23] = 8'($urandom_range(1, 60)); end
        2: begin a[30:23] = 8'($urandom_range(0, 20)); b[30:23] = 8'($urandom_range(100, 140)); end
        3: begin a[30:23] = 8'($urandom_range(100, 150)); b[30:23] = 8'($urandom_range(100, 150)); end
        default: ;
      endcase
      ref_div(a, b, m, er, ef);
      issue(a, b, m);
      finish_op($sformatf("rnd%0d_%h_%h_%0d", i, a, b, m), er, ef, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/fp_div_iter.md
FP_DIV_ITER -- requirements
Module: fp_div_iter

Interface
REQ-001 SHALL: clk  in  1  single clock; all state changes on the rising edge.
REQ-002 SHALL: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL: req  in  1  start request; sampled only when busy=0.
REQ-004 SHALL: lhs  in  32  IEEE-754 binary32 dividend.
REQ-005 SHALL: rhs  in  32  IEEE-754 binary32 divisor.
REQ-006 SHALL: rm  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM.
REQ-007 SHALL: flush  in  1  abort the in-flight operation.
REQ-008 SHALL: busy  out  1  operation in flight.
REQ-009 SHALL: done  out  1  one-cycle pulse; result and fflags are valid.
REQ-010 SHALL: result  out  32  binary32 quotient lhs/rhs.
REQ-011 SHALL: fflags  out  5  {NV,DZ,OF,UF,NX}, with NV at bit 4 and NX at bit 0.

Function
REQ-012 SHALL: FSM states are IDLE, PREP, ITER and ROUND.
- IDLE->PREP on req with busy=0.
- PREP->ITER after 1 cycle.
- ITER->ROUND after 26 cycles, counted by a 5-bit down-counter from 25 to 0.
- ROUND->IDLE after 1 cycle.
REQ-013 SHALL: if req is accepted at edge T, busy=1 for cycles T+1..T+28, done=1 in cycle T+29 only, and busy=0 in cycle T+29.
REQ-014 SHALL: all operand classes, including specials, take the fixed 29-cycle latency.
REQ-015 SHALL: req in the done cycle is accepted; req while busy=1 is ignored and not queued.
REQ-016 SHALL: result and fflags hold their values from the done cycle until the next done.
REQ-017 SHALL: lhs, rhs and rm are captured at accept; later input changes have no effect.
REQ-018 SHALL: PREP unpacks both operands, classifies them (zero/subnormal/normal/inf/qNaN/sNaN), and normalizes subnormal mantissas to 1.f using a leading-zero count with a 10-bit signed virtual exponent.
REQ-019 SHALL: PREP computes the result sign as lhs[31]^rhs[31] and the virtual exponent as ea-eb+127.
REQ-020 SHALL: ITER performs restoring radix-2 division on 24-bit normalized mantissas, producing one quotient bit per cycle (26 bits, first weight 2^0) and a 27-bit partial remainder.
REQ-021 SHALL: ROUND applies these steps in order:
- if q[25]=0, shift the quotient left 1 and decrement the exponent;
- sticky = (remainder != 0);
- if the exponent < 1, right-shift to the subnormal position, OR-ing shifted-out bits into sticky;
- round per rm, renormalizing on mantissa carry-out.
REQ-022 SHALL: rm values 101, 110 and 111 behave as RNE and raise no flag.
REQ-023 SHALL: NaN handling: any NaN operand, 0/0 or inf/inf yields 0x7FC00000. NV is set for 0/0, inf/inf or any sNaN operand; no other flags are set.
REQ-024 SHALL: finite nonzero/0 yields signed inf with DZ.
REQ-025 SHALL: inf/finite yields signed inf with no flags.
REQ-026 SHALL: finite/inf and 0/nonzero-finite yield signed zero with no flags.
REQ-027 SHALL: on overflow, set OF and NX.
- RNE and RMM give signed inf.
- RTZ gives signed 0x7F7FFFFF magnitude.
- RDN gives +max finite or -inf.
- RUP gives +inf or -max finite.
REQ-028 SHALL: UF is set when the result is tiny after rounding (RISC-V) and inexact. NX is set whenever any discarded bit is nonzero.
REQ-029 SHALL: flush=1 in any cycle forces IDLE at the next edge.
- No done is produced for the aborted operation.
- busy=0 from the next cycle.
- result and fflags keep their previous values.
REQ-030 SHALL: flush and req in the same cycle: flush wins and req is ignored.

Reset
REQ-031 SHALL: rst_n=0 immediately forces IDLE, busy=0, done=0, result=0x00000000, fflags=0, counter=0, regardless of clk.
REQ-032 SHALL: reset asserted mid-operation discards the operation; no done follows release.
REQ-033 SHALL: after rst_n rises, req is accepted at the first clk edge.

Verification
REQ-034 SHALL: 0x40400000/0x40000000, RNE, req at T -> done at T+29, 0x3FC00000, fflags 0x00, busy high T+1..T+28.
REQ-035 SHALL: 0x3F800000/0x40400000 -> RNE 0x3EAAAAAB, fflags 0x01; RTZ 0x3EAAAAAA, fflags 0x01.
REQ-036 SHALL: specials -> 0x3F800000/0x00000000 gives 0x7F800000, fflags 0x08; 0x00000000/0x00000000 gives 0x7FC00000, fflags 0x10; 0x7F800001/0x3F800000 gives 0x7FC00000, fflags 0x10.
REQ-037 SHALL: 0x7F7FFFFF/0x3F000000 -> RNE 0x7F800000, fflags 0x05; RTZ 0x7F7FFFFF, fflags 0x05.
REQ-038 SHALL: 0x00000001/0x40000000 RNE -> 0x00000000, fflags 0x03; 0x00800000/0x40000000 RNE -> 0x00400000, fflags 0x00.
REQ-039 SHALL: control corners:
- flush at T+10 -> no done, busy=0 at T+11;
- rst_n pulse at T+15 -> outputs zero, no done;
- back-to-back req in the done cycle -> second done exactly 29 cycles later.
